// File: rtl/cpu_axi_pkg.sv
// Shared types and constants for the CPU AXI read-channel arbiter.
// The FSM state type, port-select encoding and common AXI field values live here.
package cpu_axi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AR   = 2'd1,
    ST_R    = 2'd2
  } state_t;

  localparam logic SEL_INST = 1'b0;
  localparam logic SEL_MEM  = 1'b1;

  localparam logic [2:0] SIZE_4B    = 3'b010;
  localparam logic [1:0] BURST_INCR = 2'b01;

endpackage

// File: rtl/rr_arb2.sv
// Two-request round-robin arbiter. On a tie the requester not granted last wins.
// The pointer remembers the last granted port and starts at inst.
module rr_arb2
  import cpu_axi_pkg::*;
(
  input  logic       cpu_clk,
  input  logic       cpu_reset,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt,
  output logic       ptr
);

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = (ptr == SEL_INST) ? 2'b10 : 2'b01;
        default: gnt = 2'b00;
      endcase
    end
  end

  always_ff @(posedge cpu_clk) begin
    if (cpu_reset) begin
      ptr <= SEL_INST;
    end else if (|gnt) begin
      ptr <= gnt[1];
    end
  end

endmodule

// File: rtl/cpu_axi_rd_arbiter.sv
// Merges the instruction and data AXI read ports into one downstream read master.
// One transaction in flight; R beats pass through combinationally to the selected port.
module cpu_axi_rd_arbiter
  import cpu_axi_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              cpu_clk,
  input  logic              cpu_reset,

  input  logic [ADDR_W-1:0] s_inst_araddr,
  input  logic [2:0]        s_inst_arsize,
  input  logic [1:0]        s_inst_arburst,
  input  logic [7:0]        s_inst_arlen,
  input  logic              s_inst_arvalid,
  output logic              s_inst_arready,
  output logic [DATA_W-1:0] s_inst_rdata,
  output logic              s_inst_rlast,
  output logic              s_inst_rvalid,
  input  logic              s_inst_rready,

  input  logic [ADDR_W-1:0] s_mem_araddr,
  input  logic [2:0]        s_mem_arsize,
  input  logic [1:0]        s_mem_arburst,
  input  logic [7:0]        s_mem_arlen,
  input  logic              s_mem_arvalid,
  output logic              s_mem_arready,
  output logic [DATA_W-1:0] s_mem_rdata,
  output logic              s_mem_rlast,
  output logic              s_mem_rvalid,
  input  logic              s_mem_rready,

  output logic [ADDR_W-1:0] m_araddr,
  output logic [2:0]        m_arsize,
  output logic [1:0]        m_arburst,
  output logic [7:0]        m_arlen,
  output logic              m_arvalid,
  input  logic              m_arready,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_rlast,
  input  logic              m_rvalid,
  output logic              m_rready,

  output logic [31:0]       inst_grant_cnt,
  output logic [31:0]       mem_grant_cnt,

  output logic [1:0]        dbg_state,
  output logic              dbg_ptr
);

  // Handshakes: a transfer occurs on a rising edge where valid and ready are both
  // high; valid never waits on ready, and payload holds steady while valid is up.

  state_t      state, state_nxt;
  logic        sel;
  logic [1:0]  req;
  logic [1:0]  gnt;
  logic        en;
  logic [31:0] inst_cnt, mem_cnt;

  assign req = {s_mem_arvalid, s_inst_arvalid};
  assign en  = (state == ST_IDLE);

  rr_arb2 u_arb (
    .cpu_clk   (cpu_clk),
    .cpu_reset (cpu_reset),
    .req       (req),
    .en        (en),
    .gnt       (gnt),
    .ptr       (dbg_ptr)
  );

  assign dbg_state      = state;
  assign inst_grant_cnt = inst_cnt;
  assign mem_grant_cnt  = mem_cnt;

  always_comb begin
    state_nxt      = state;
    s_inst_arready = 1'b0;
    s_mem_arready  = 1'b0;
    s_inst_rvalid  = 1'b0;
    s_inst_rdata   = '0;
    s_inst_rlast   = 1'b0;
    s_mem_rvalid   = 1'b0;
    s_mem_rdata    = '0;
    s_mem_rlast    = 1'b0;
    m_rready       = 1'b0;
    case (state)
      ST_IDLE: begin
        s_inst_arready = gnt[0];
        s_mem_arready  = gnt[1];
        if (|gnt) state_nxt = ST_AR;
      end
      ST_AR: begin
        if (m_arvalid && m_arready) state_nxt = ST_R;
      end
      ST_R: begin
        if (sel == SEL_MEM) begin
          s_mem_rvalid = m_rvalid;
          s_mem_rdata  = m_rdata;
          s_mem_rlast  = m_rlast;
          m_rready     = s_mem_rready;
        end else begin
          s_inst_rvalid = m_rvalid;
          s_inst_rdata  = m_rdata;
          s_inst_rlast  = m_rlast;
          m_rready      = s_inst_rready;
        end
        if (m_rvalid && m_rready && m_rlast) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge cpu_clk) begin
    if (cpu_reset) begin
      state     <= ST_IDLE;
      sel       <= SEL_INST;
      m_araddr  <= '0;
      m_arsize  <= '0;
      m_arburst <= '0;
      m_arlen   <= '0;
      m_arvalid <= 1'b0;
      inst_cnt  <= '0;
      mem_cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE && (|gnt)) begin
        sel       <= gnt[1];
        m_arvalid <= 1'b1;
        if (gnt[1]) begin
          m_araddr  <= s_mem_araddr;
          m_arsize  <= s_mem_arsize;
          m_arburst <= s_mem_arburst;
          m_arlen   <= s_mem_arlen;
          mem_cnt   <= mem_cnt + 32'd1;
        end else begin
          m_araddr  <= s_inst_araddr;
          m_arsize  <= s_inst_arsize;
          m_arburst <= s_inst_arburst;
          m_arlen   <= s_inst_arlen;
          inst_cnt  <= inst_cnt + 32'd1;
        end
      end else if (state == ST_AR && m_arready) begin
        m_arvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cpu_axi_rd_arbiter.sv
// Directed bench for cpu_axi_rd_arbiter: grants, AR hold, R passthrough,
// bursts with back-pressure, mid-transaction reset and counter wrap.
module tb_cpu_axi_rd_arbiter;
  import cpu_axi_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] s_inst_araddr, s_mem_araddr;
  logic [2:0]  s_inst_arsize, s_mem_arsize;
  logic [1:0]  s_inst_arburst, s_mem_arburst;
  logic [7:0]  s_inst_arlen, s_mem_arlen;
  logic        s_inst_arvalid, s_inst_arready, s_mem_arvalid, s_mem_arready;
  logic [31:0] s_inst_rdata, s_mem_rdata;
  logic        s_inst_rlast, s_inst_rvalid, s_inst_rready;
  logic        s_mem_rlast, s_mem_rvalid, s_mem_rready;
  logic [31:0] m_araddr;
  logic [2:0]  m_arsize;
  logic [1:0]  m_arburst;
  logic [7:0]  m_arlen;
  logic        m_arvalid, m_arready;
  logic [31:0] m_rdata;
  logic        m_rlast, m_rvalid, m_rready;
  logic [31:0] inst_grant_cnt, mem_grant_cnt;
  logic [1:0]  dbg_state;
  logic        dbg_ptr;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cpu_axi_rd_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .cpu_clk(clk), .cpu_reset(rst),
    .s_inst_araddr(s_inst_araddr), .s_inst_arsize(s_inst_arsize),
    .s_inst_arburst(s_inst_arburst), .s_inst_arlen(s_inst_arlen),
    .s_inst_arvalid(s_inst_arvalid), .s_inst_arready(s_inst_arready),
    .s_inst_rdata(s_inst_rdata), .s_inst_rlast(s_inst_rlast),
    .s_inst_rvalid(s_inst_rvalid), .s_inst_rready(s_inst_rready),
    .s_mem_araddr(s_mem_araddr), .s_mem_arsize(s_mem_arsize),
    .s_mem_arburst(s_mem_arburst), .s_mem_arlen(s_mem_arlen),
    .s_mem_arvalid(s_mem_arvalid), .s_mem_arready(s_mem_arready),
    .s_mem_rdata(s_mem_rdata), .s_mem_rlast(s_mem_rlast),
    .s_mem_rvalid(s_mem_rvalid), .s_mem_rready(s_mem_rready),
    .m_araddr(m_araddr), .m_arsize(m_arsize), .m_arburst(m_arburst),
    .m_arlen(m_arlen), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rlast(m_rlast), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .inst_grant_cnt(inst_grant_cnt), .mem_grant_cnt(mem_grant_cnt),
    .dbg_state(dbg_state), .dbg_ptr(dbg_ptr)
  );

  // ---------------- clock / reset ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    s_inst_araddr = '0; s_inst_arsize = SIZE_4B; s_inst_arburst = BURST_INCR;
    s_inst_arlen = '0; s_inst_arvalid = 1'b0; s_inst_rready = 1'b0;
    s_mem_araddr = '0; s_mem_arsize = SIZE_4B; s_mem_arburst = BURST_INCR;
    s_mem_arlen = '0; s_mem_arvalid = 1'b0; s_mem_rready = 1'b0;
    m_arready = 1'b0; m_rdata = '0; m_rlast = 1'b0; m_rvalid = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  // ---------------- driver tasks ----------------
  // Waits (bounded) for m_arvalid, captures the address, and accepts it.
  task automatic serve_ar(output logic [31:0] addr);
    int n = 0;
    #1;
    while (m_arvalid !== 1'b1 && n < 20) begin tick(); #1; n++; end
    total++;
    if (m_arvalid !== 1'b1) begin
      bad++;
      $display("FAIL ar_wait m_arvalid=%b required=1", m_arvalid);
    end
    addr = m_araddr;
    m_arready = 1'b1;
    tick();
    m_arready = 1'b0;
  endtask

  // Delivers one last beat once the DUT is ready to take it (bounded).
  task automatic serve_r_single(input logic [31:0] data);
    int n = 0;
    m_rvalid = 1'b1; m_rdata = data; m_rlast = 1'b1;
    #1;
    while (m_rready !== 1'b1 && n < 20) begin tick(); #1; n++; end
    total++;
    if (m_rready !== 1'b1) begin
      bad++;
      $display("FAIL r_wait m_rready=%b required=1", m_rready);
    end
    tick();
    m_rvalid = 1'b0; m_rlast = 1'b0; m_rdata = '0;
  endtask

  // Waits (bounded) for either upstream arready; returns 1 for mem, 0 for inst.
  task automatic wait_grant(output logic winner);
    int n = 0;
    #1;
    while (!(s_inst_arready === 1'b1 || s_mem_arready === 1'b1) && n < 20) begin
      tick(); #1; n++;
    end
    total++;
    if (!(s_inst_arready ^ s_mem_arready)) begin
      bad++;
      $display("FAIL grant_wait inst_arready=%b mem_arready=%b required=one-hot",
               s_inst_arready, s_mem_arready);
    end
    winner = s_mem_arready;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    #1;
    total++;
    if ({m_arvalid, m_rready, s_inst_arready, s_mem_arready, s_inst_rvalid,
         s_mem_rvalid, s_inst_rlast, s_mem_rlast} !== 8'b0) begin
      bad++;
      $display("FAIL reset_ctrl got=%b required=0", {m_arvalid, m_rready,
               s_inst_arready, s_mem_arready, s_inst_rvalid, s_mem_rvalid,
               s_inst_rlast, s_mem_rlast});
    end
    total++;
    if ({m_araddr, m_arsize, m_arburst, m_arlen} !== '0) begin
      bad++;
      $display("FAIL reset_payload addr=%h size=%h burst=%h len=%h required=0",
               m_araddr, m_arsize, m_arburst, m_arlen);
    end
    total++;
    if (inst_grant_cnt !== 32'd0 || mem_grant_cnt !== 32'd0 ||
        dbg_state !== ST_IDLE || dbg_ptr !== SEL_INST) begin
      bad++;
      $display("FAIL reset_state inst=%0d mem=%0d state=%0d ptr=%b required=0/0/0/0",
               inst_grant_cnt, mem_grant_cnt, dbg_state, dbg_ptr);
    end
  endtask

  task automatic test_single_inst();
    do_reset();
    s_inst_araddr = 32'h0000_1000; s_inst_arlen = 8'd0; s_inst_arvalid = 1'b1;
    #1;
    total++;
    if (s_inst_arready !== 1'b1 || s_mem_arready !== 1'b0) begin
      bad++;
      $display("FAIL single_arready inst=%b mem=%b required=1/0", s_inst_arready, s_mem_arready);
    end
    tick();
    s_inst_arvalid = 1'b0;
    #1;
    total++;
    if (m_arvalid !== 1'b1 || m_araddr !== 32'h1000 || m_arsize !== SIZE_4B ||
        m_arlen !== 8'd0 || inst_grant_cnt !== 32'd1 || dbg_state !== ST_AR) begin
      bad++;
      $display("FAIL single_ar1 valid=%b addr=%h size=%h len=%h cnt=%0d state=%0d required=1/1000/2/0/1/1",
               m_arvalid, m_araddr, m_arsize, m_arlen, inst_grant_cnt, dbg_state);
    end
    tick();
    total++;
    if (m_arvalid !== 1'b1 || m_araddr !== 32'h1000 || s_inst_arready !== 1'b0) begin
      bad++;
      $display("FAIL single_ar2 valid=%b addr=%h arready=%b required=1/1000/0",
               m_arvalid, m_araddr, s_inst_arready);
    end
    m_arready = 1'b1;
    tick();
    m_arready = 1'b0;
    m_rvalid = 1'b1; m_rdata = 32'hDEAD_BEEF; m_rlast = 1'b1; s_inst_rready = 1'b1;
    #1;
    total++;
    if (m_arvalid !== 1'b0 || dbg_state !== ST_R || s_inst_rvalid !== 1'b1 ||
        s_inst_rdata !== 32'hDEAD_BEEF || s_inst_rlast !== 1'b1 || m_rready !== 1'b1) begin
      bad++;
      $display("FAIL single_r arvalid=%b state=%0d rvalid=%b rdata=%h rlast=%b rready=%b required=0/2/1/deadbeef/1/1",
               m_arvalid, dbg_state, s_inst_rvalid, s_inst_rdata, s_inst_rlast, m_rready);
    end
    total++;
    if (s_mem_rvalid !== 1'b0 || s_mem_rdata !== 32'd0 || s_mem_rlast !== 1'b0) begin
      bad++;
      $display("FAIL single_mem_quiet rvalid=%b rdata=%h rlast=%b required=0/0/0",
               s_mem_rvalid, s_mem_rdata, s_mem_rlast);
    end
    tick();
    m_rvalid = 1'b0; m_rlast = 1'b0; s_inst_rready = 1'b0;
    #1;
    total++;
    if (dbg_state !== ST_IDLE || m_rready !== 1'b0 || s_inst_rvalid !== 1'b0) begin
      bad++;
      $display("FAIL single_done state=%0d rready=%b rvalid=%b required=0/0/0",
               dbg_state, m_rready, s_inst_rvalid);
    end
  endtask

  task automatic test_simultaneous();
    logic [31:0] a;
    logic        w;
    do_reset();
    s_inst_rready = 1'b1; s_mem_rready = 1'b1;
    s_inst_araddr = 32'h100; s_mem_araddr = 32'h8000;
    s_inst_arvalid = 1'b1; s_mem_arvalid = 1'b1;
    wait_grant(w);
    total++;
    if (w !== 1'b1) begin
      bad++;
      $display("FAIL sim_first winner=%b required=1(mem)", w);
    end
    tick();
    s_mem_arvalid = 1'b0;
    serve_ar(a);
    total++;
    if (a !== 32'h8000) begin
      bad++;
      $display("FAIL sim_addr0 got=%h required=8000", a);
    end
    serve_r_single(32'h1111_0000);
    wait_grant(w);
    total++;
    if (w !== 1'b0) begin
      bad++;
      $display("FAIL sim_second winner=%b required=0(inst)", w);
    end
    tick();
    s_inst_arvalid = 1'b0;
    serve_ar(a);
    total++;
    if (a !== 32'h100) begin
      bad++;
      $display("FAIL sim_addr1 got=%h required=100", a);
    end
    serve_r_single(32'h2222_0000);
    total++;
    if (inst_grant_cnt !== 32'd1 || mem_grant_cnt !== 32'd1) begin
      bad++;
      $display("FAIL sim_cnt inst=%0d mem=%0d required=1/1", inst_grant_cnt, mem_grant_cnt);
    end
    s_inst_rready = 1'b0; s_mem_rready = 1'b0;
  endtask

  task automatic test_contention();
    logic [3:0]  exp_seq;
    logic [31:0] a;
    logic        w;
    exp_seq = 4'b0101;  // index 0 first: mem, inst, mem, inst
    do_reset();
    s_inst_rready = 1'b1; s_mem_rready = 1'b1;
    s_inst_araddr = 32'h0000_0200; s_mem_araddr = 32'h0000_9000;
    s_inst_arvalid = 1'b1; s_mem_arvalid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_grant(w);
      total++;
      if (w !== exp_seq[i]) begin
        bad++;
        $display("FAIL contend_grant%0d winner=%b required=%b", i, w, exp_seq[i]);
      end
      tick();
      serve_ar(a);
      total++;
      if (a !== (exp_seq[i] ? 32'h9000 : 32'h200)) begin
        bad++;
        $display("FAIL contend_addr%0d got=%h required=%h", i, a,
                 exp_seq[i] ? 32'h9000 : 32'h200);
      end
      serve_r_single(32'hC0DE_0000 + i);
    end
    s_inst_arvalid = 1'b0; s_mem_arvalid = 1'b0;
    #1;
    total++;
    if (inst_grant_cnt !== 32'd2 || mem_grant_cnt !== 32'd2) begin
      bad++;
      $display("FAIL contend_cnt inst=%0d mem=%0d required=2/2", inst_grant_cnt, mem_grant_cnt);
    end
    s_inst_rready = 1'b0; s_mem_rready = 1'b0;
  endtask

  task automatic test_burst();
    logic [5:0]  rdy_pat;
    logic [31:0] exp_q[$];
    logic [31:0] a;
    int          beat;
    rdy_pat = 6'b101101;  // bit 0 first: 1,0,1,1,0,1
    for (int i = 0; i < 4; i++) exp_q.push_back(32'hB000_00A0 + i);
    do_reset();
    s_mem_araddr = 32'h2000; s_mem_arlen = 8'd3; s_mem_arvalid = 1'b1;
    tick();
    s_mem_arvalid = 1'b0;
    #1;
    total++;
    if (m_arlen !== 8'd3 || m_arburst !== BURST_INCR || m_araddr !== 32'h2000) begin
      bad++;
      $display("FAIL burst_ar len=%0d burst=%b addr=%h required=3/01/2000",
               m_arlen, m_arburst, m_araddr);
    end
    serve_ar(a);
    beat = 0;
    for (int c = 0; c < 6; c++) begin
      m_rvalid = 1'b1;
      m_rdata = 32'hB000_00A0 + beat;
      m_rlast = (beat == 3);
      s_mem_rready = rdy_pat[c];
      #1;
      total++;
      if (dbg_state !== ST_R || s_mem_rvalid !== 1'b1 || m_rready !== rdy_pat[c] ||
          s_inst_rvalid !== 1'b0) begin
        bad++;
        $display("FAIL burst_cycle%0d state=%0d rvalid=%b rready=%b inst_rvalid=%b required=2/1/%b/0",
                 c, dbg_state, s_mem_rvalid, m_rready, s_inst_rvalid, rdy_pat[c]);
      end
      if (rdy_pat[c]) begin
        total++;
        if (exp_q.size() == 0 || s_mem_rdata !== exp_q[0]) begin
          bad++;
          $display("FAIL burst_data%0d got=%h required=%h", beat, s_mem_rdata,
                   exp_q.size() ? exp_q[0] : 32'hx);
        end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        beat++;
      end
      tick();
    end
    m_rvalid = 1'b0; m_rlast = 1'b0; s_mem_rready = 1'b0;
    #1;
    total++;
    if (dbg_state !== ST_IDLE || exp_q.size() != 0 || beat != 4) begin
      bad++;
      $display("FAIL burst_end state=%0d left=%0d beats=%0d required=0/0/4",
               dbg_state, exp_q.size(), beat);
    end
  endtask

  task automatic test_reset_mid_r();
    logic [31:0] a;
    logic        w;
    do_reset();
    s_mem_araddr = 32'h3000; s_mem_arlen = 8'd3; s_mem_arvalid = 1'b1;
    tick();
    s_mem_arvalid = 1'b0;
    serve_ar(a);
    m_rvalid = 1'b1; m_rdata = 32'h5555_0001; m_rlast = 1'b0; s_mem_rready = 1'b1;
    tick();
    m_rdata = 32'h5555_0002;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    total++;
    if (m_rready !== 1'b0 || m_arvalid !== 1'b0 || dbg_state !== ST_IDLE ||
        s_mem_rvalid !== 1'b0 || mem_grant_cnt !== 32'd0 || inst_grant_cnt !== 32'd0) begin
      bad++;
      $display("FAIL midr_reset rready=%b arvalid=%b state=%0d rvalid=%b cnt=%0d/%0d required=0/0/0/0/0/0",
               m_rready, m_arvalid, dbg_state, s_mem_rvalid, inst_grant_cnt, mem_grant_cnt);
    end
    m_rvalid = 1'b0; s_mem_rready = 1'b0;
    s_inst_araddr = 32'h4000; s_inst_arvalid = 1'b1; s_inst_rready = 1'b1;
    wait_grant(w);
    tick();
    s_inst_arvalid = 1'b0;
    serve_ar(a);
    m_rvalid = 1'b1; m_rdata = 32'h600D_F00D; m_rlast = 1'b1;
    #1;
    total++;
    if (a !== 32'h4000 || s_inst_rvalid !== 1'b1 || s_inst_rdata !== 32'h600D_F00D ||
        inst_grant_cnt !== 32'd1) begin
      bad++;
      $display("FAIL midr_fresh addr=%h rvalid=%b rdata=%h cnt=%0d required=4000/1/600df00d/1",
               a, s_inst_rvalid, s_inst_rdata, inst_grant_cnt);
    end
    tick();
    m_rvalid = 1'b0; m_rlast = 1'b0; s_inst_rready = 1'b0;
  endtask

  task automatic test_counter_wrap();
    logic [31:0] a;
    do_reset();
    force dut.mem_cnt = 32'hFFFF_FFFF;
    tick();
    release dut.mem_cnt;
    #1;
    total++;
    if (mem_grant_cnt !== 32'hFFFF_FFFF) begin
      bad++;
      $display("FAIL wrap_preload got=%h required=ffffffff", mem_grant_cnt);
    end
    s_mem_araddr = 32'h5000; s_mem_arvalid = 1'b1; s_mem_rready = 1'b1;
    tick();
    s_mem_arvalid = 1'b0;
    #1;
    total++;
    if (mem_grant_cnt !== 32'd0 || inst_grant_cnt !== 32'd0) begin
      bad++;
      $display("FAIL wrap_cnt mem=%h inst=%h required=0/0", mem_grant_cnt, inst_grant_cnt);
    end
    serve_ar(a);
    serve_r_single(32'h7777_7777);
    s_mem_rready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_inst();
    test_simultaneous();
    test_contention();
    test_burst();
    test_reset_mid_r();
    test_counter_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
